retire_ctrl: RTL and testbench
==============================

Name: retire_ctrl

Overview:
- Parametrised, stateful successor to the combinational retire stage.
- Commits up to N ROB head entries per cycle, oldest to youngest, in order.
- Adds the following over the combinational stage:
  - a mispredict on any lane, not only the oldest;
  - a store-commit budget per cycle;
  - halt detection;
  - a multi-cycle recovery window;
  - registered architectural-map and freelist updates;
  - performance counters.
- Sits between the ROB head window and the arch map table, freelist, branch predictor and store queue.

Parameters:
N, `N, retire width (head window lanes; lane N-1 is oldest).
PHYS_REGS, `PHYS_REG_SZ_R10K, physical register count; PRW = clog2(PHYS_REGS).
STORE_PORTS, 1, maximum stores committed per cycle.
RECOVER_CYCLES, 2, cycles retire is blocked after a mispredict (must be ≥1).
CNT_W, 64, width of the performance counters.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-low reset (0 = reset).
headEntries  in  ROB_ENTRY[N]  ROB head window; fields branch, complete, pred_taken, branch_taken, pred_target, branch_target, arch_rd, phys_rd, prev_phys_rd.
headValids  in  N  lane valid.
headIdxs  in  ROB_IDX[N]  ROB index per lane.
headIsStore  in  N  lane is a store.
headIsHalt  in  N  lane is a halt.
sqCommitReady  in  1  store queue accepts commits this cycle.
robRetireCount  out  clog2(N+1)  entries popped this cycle (combinational).
robMispredict  out  1  flush everything younger than robMispredIdx (combinational).
robMispredIdx  out  ROB_IDX  index of the mispredicted branch.
sqCommitCount  out  clog2(STORE_PORTS+1)  stores committed this cycle (combinational).
bpRecoverEn  out  1  one-cycle recovery pulse (registered).
freeMask  out  PHYS_REGS  PRs to free (registered).
archWriteEnables  out  N  arch map write enables (registered).
archWriteAddrs  out  REG_IDX[N]  arch map write addresses (registered).
archWritePhysRegs  out  PHYS_TAG[N]  arch map write data (registered).
halted  out  1  sticky halt (registered).
instRetiredCnt  out  CNT_W  total instructions retired.
mispredCnt  out  CNT_W  total mispredicts.

Behaviour:
- States and transitions:
  - RUN → RECOVER on a mispredict.
  - RUN → HALTED on a retired halt.
  - RECOVER → RUN when the recover counter reaches 0.
  - HALTED is terminal until reset.
- Reset (reset==0 at a clock edge):
  - state = RUN; recover counter = 0.
  - All registered outputs are 0; both counters are 0.
  - Reset mid-RECOVER or in HALTED returns to RUN.
- Combinational scan, RUN state only. Walk w = N-1 down to 0 and stop at the first lane that:
  - is not valid (lanes retire contiguously from the oldest);
  - is not complete;
  - is a store when sqCommitReady==0, or when STORE_PORTS stores have already been taken this cycle.
- Each accepted lane retires:
  - robRetireCount is incremented;
  - stores increment sqCommitCount.
- Lanes after a stop never retire that cycle, even if they are complete.
- Mispredict:
  - Definition: branch && complete && ((pred_taken != branch_taken) || (branch_taken && pred_target != branch_target)).
  - The branch lane itself retires, including its dest write if arch_rd≠0.
  - The scan stops after that lane.
  - robMispredict = 1 and robMispredIdx = headIdxs[w] in the same cycle.
  - Next edge: bpRecoverEn = 1 for exactly one cycle; state becomes RECOVER with counter = RECOVER_CYCLES.
- Halt: the halt lane retires and the scan stops. Next edge: state = HALTED and halted = 1 (sticky).
- Same lane is both halt and mispredict: the mispredict takes priority and the halt is ignored.
- RECOVER and HALTED states:
  - robRetireCount, sqCommitCount and robMispredict are 0.
  - Registered write outputs are 0 on the following edge.
  - In RECOVER the counter decrements each cycle; the state returns to RUN on the cycle after the counter reaches 1, so retire is blocked for exactly RECOVER_CYCLES cycles.
- Registered outputs (latched one edge after the scan):
  - For each retired lane with arch_rd≠0: archWriteEnables[w]=1, archWriteAddrs[w]=arch_rd, archWritePhysRegs[w]=phys_rd.
  - Also set freeMask[prev_phys_rd] when prev_phys_rd≠0 and prev_phys_rd<PHYS_REGS.
  - All other bits are 0 each cycle; these outputs are pulses, not held.
  - Two lanes writing the same arch_rd: both enables assert; the arch map resolves the youngest-wins rule.
- Counters:
  - instRetiredCnt += robRetireCount each cycle.
  - mispredCnt += 1 per mispredict.
  - Both wrap modulo 2^CNT_W.
- Outputs never depend on X: invalid lanes are fully masked.

Test Plan:
- N=3, all three lanes valid and complete, arch_rd = 5/6/0, prev_phys_rd = 40/41/x → robRetireCount=3; next cycle archWriteEnables=3'b110, freeMask bits 40 and 41 set, instRetiredCnt=3.
- Lane 2 complete, lane 1 incomplete, lane 0 complete → robRetireCount=1; only lane 2 writes next cycle.
- Lane 1 is a branch with pred_taken=0, branch_taken=1 → robRetireCount=2, robMispredict=1, robMispredIdx=headIdxs[1]; bpRecoverEn=1 for one cycle; retire stays 0 for 2 cycles (RECOVER_CYCLES=2) with valid, complete heads; mispredCnt=1.
- STORE_PORTS=1, lanes 2 and 1 are stores, sqCommitReady=1 → retire=1, sqCommitCount=1. Then sqCommitReady=0 with a store at lane 2 → retire=0.
- Halt at lane 1 → lane 0 is not retired; halted=1 next cycle and stays 1 while complete heads are presented; reset=0 for one cycle → halted=0, counters 0, retiring resumes.
- reset asserted during cycle 1 of RECOVER → RUN on the next cycle, bpRecoverEn=0, retire resumes immediately.

Source files
------------

// File: rtl/retire_ctrl.sv
// retire_ctrl: in-order commit of up to N ROB head entries per cycle.
//   Scans the head window oldest (lane N-1) to youngest (lane 0) and stops at
//   the first lane that is invalid, incomplete or a store that cannot commit.
//   Handles mispredicts on any lane, halts, a blocking recovery window,
//   registered arch-map/freelist updates and performance counters.
// Ports:
//   clock, reset               clock, synchronous active-low reset
//   headEntries/Valids/Idxs    ROB head window (lane N-1 oldest)
//   headIsStore/headIsHalt     per-lane store / halt flags
//   sqCommitReady              store queue can accept commits this cycle
//   robRetireCount             entries popped this cycle (comb)
//   robMispredict/MispredIdx   flush request and branch index (comb)
//   sqCommitCount              stores committed this cycle (comb)
//   bpRecoverEn                one-cycle predictor recovery pulse (reg)
//   freeMask                   physical regs to free (reg, pulse)
//   archWrite*                 arch map write port per lane (reg, pulse)
//   halted                     sticky halt (reg)
//   instRetiredCnt/mispredCnt  performance counters (reg)

package retire_pkg;
   localparam int PHYS_REGS_DEF = 64;
   localparam int PRW           = $clog2(PHYS_REGS_DEF);
   localparam int ROB_IDX_W     = 5;
   localparam int REG_IDX_W     = 5;
   localparam int XLEN          = 32;

   typedef struct packed {
      logic                 branch;
      logic                 complete;
      logic                 pred_taken;
      logic                 branch_taken;
      logic [XLEN-1:0]      pred_target;
      logic [XLEN-1:0]      branch_target;
      logic [REG_IDX_W-1:0] arch_rd;
      logic [PRW-1:0]       phys_rd;
      logic [PRW-1:0]       prev_phys_rd;
   } rob_entry_t;
endpackage

module retire_ctrl
   import retire_pkg::*;
#(
   parameter int N              = 3,
   parameter int PHYS_REGS      = PHYS_REGS_DEF,
   parameter int STORE_PORTS    = 1,
   parameter int RECOVER_CYCLES = 2,
   parameter int CNT_W          = 64
) (
   input  logic                                clock,
   input  logic                                reset,
   input  rob_entry_t [N-1:0]                  headEntries,
   input  logic [N-1:0]                        headValids,
   input  logic [N-1:0][ROB_IDX_W-1:0]         headIdxs,
   input  logic [N-1:0]                        headIsStore,
   input  logic [N-1:0]                        headIsHalt,
   input  logic                                sqCommitReady,
   output logic [$clog2(N+1)-1:0]              robRetireCount,
   output logic                                robMispredict,
   output logic [ROB_IDX_W-1:0]                robMispredIdx,
   output logic [$clog2(STORE_PORTS+1)-1:0]    sqCommitCount,
   output logic                                bpRecoverEn,
   output logic [PHYS_REGS-1:0]                freeMask,
   output logic [N-1:0]                        archWriteEnables,
   output logic [N-1:0][REG_IDX_W-1:0]         archWriteAddrs,
   output logic [N-1:0][PRW-1:0]               archWritePhysRegs,
   output logic                                halted,
   output logic [CNT_W-1:0]                    instRetiredCnt,
   output logic [CNT_W-1:0]                    mispredCnt
);
   localparam int CW = $clog2(N+1);
   localparam int SW = $clog2(STORE_PORTS+1);
   localparam int RW = $clog2(RECOVER_CYCLES+1);

   typedef enum logic [1:0] {S_RUN, S_RECOVER, S_HALTED} state_t;

   state_t                      r_state;
   logic [RW-1:0]               r_rcnt;
   logic [N-1:0]                w_misp_lane;
   logic [N-1:0]                w_ret;
   logic [N-1:0]                w_we;
   logic [N-1:0][REG_IDX_W-1:0] w_addr;
   logic [N-1:0][PRW-1:0]       w_phys;
   logic [PHYS_REGS-1:0]        w_free;
   logic                        w_halt;
   logic                        w_stop;

   always_comb begin
      for (int w = 0; w < N; w++) begin
         w_misp_lane[w] = headEntries[w].branch && headEntries[w].complete &&
            ((headEntries[w].pred_taken != headEntries[w].branch_taken) ||
             (headEntries[w].branch_taken &&
              (headEntries[w].pred_target != headEntries[w].branch_target)));
      end
   end

   // Oldest-first scan; w_stop latches the first blocking lane so younger
   // lanes never retire past it. Outside RUN the scan is fully suppressed.
   always_comb begin
      w_ret          = '0;
      robRetireCount = '0;
      sqCommitCount  = '0;
      robMispredict  = 1'b0;
      robMispredIdx  = '0;
      w_halt         = 1'b0;
      w_stop         = (r_state != S_RUN);
      for (int w = N-1; w >= 0; w--) begin
         if (!w_stop) begin
            if (!headValids[w] || !headEntries[w].complete ||
                (headIsStore[w] && (!sqCommitReady || sqCommitCount == SW'(STORE_PORTS)))) begin
               w_stop = 1'b1;
            end else begin
               w_ret[w]       = 1'b1;
               robRetireCount = robRetireCount + CW'(1);
               if (headIsStore[w]) sqCommitCount = sqCommitCount + SW'(1);
               // Mispredict wins over halt on the same lane.
               if (w_misp_lane[w]) begin
                  robMispredict = 1'b1;
                  robMispredIdx = headIdxs[w];
                  w_stop        = 1'b1;
               end else if (headIsHalt[w]) begin
                  w_halt = 1'b1;
                  w_stop = 1'b1;
               end
            end
         end
      end
   end

   // Arch map writes and freelist bits for retired lanes with a real dest.
   always_comb begin
      w_we   = '0;
      w_addr = '0;
      w_phys = '0;
      w_free = '0;
      for (int w = 0; w < N; w++) begin
         if (w_ret[w] && (headEntries[w].arch_rd != '0)) begin
            w_we[w]   = 1'b1;
            w_addr[w] = headEntries[w].arch_rd;
            w_phys[w] = headEntries[w].phys_rd;
            if ((headEntries[w].prev_phys_rd != '0) &&
                (int'(headEntries[w].prev_phys_rd) < PHYS_REGS))
               w_free[headEntries[w].prev_phys_rd] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state           <= S_RUN;
         r_rcnt            <= '0;
         bpRecoverEn       <= 1'b0;
         freeMask          <= '0;
         archWriteEnables  <= '0;
         archWriteAddrs    <= '0;
         archWritePhysRegs <= '0;
         halted            <= 1'b0;
         instRetiredCnt    <= '0;
         mispredCnt        <= '0;
      end else begin
         bpRecoverEn       <= 1'b0;
         freeMask          <= w_free;
         archWriteEnables  <= w_we;
         archWriteAddrs    <= w_addr;
         archWritePhysRegs <= w_phys;
         instRetiredCnt    <= instRetiredCnt + CNT_W'(robRetireCount);
         mispredCnt        <= mispredCnt + CNT_W'(robMispredict);
         case (r_state)
            S_RUN: begin
               if (robMispredict) begin
                  r_state     <= S_RECOVER;
                  r_rcnt      <= RW'(RECOVER_CYCLES);
                  bpRecoverEn <= 1'b1;
               end else if (w_halt) begin
                  r_state <= S_HALTED;
                  halted  <= 1'b1;
               end
            end
            // Leaving when the counter is at 1 blocks retire for exactly
            // RECOVER_CYCLES cycles.
            S_RECOVER: begin
               if (r_rcnt <= RW'(1)) begin
                  r_state <= S_RUN;
                  r_rcnt  <= '0;
               end else begin
                  r_rcnt <= r_rcnt - RW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_retire_ctrl.sv
// Bench for retire_ctrl (N=3, 64 physical regs, 1 store port, 2 recover cycles).
module tb_retire_ctrl;
   import retire_pkg::*;
   localparam int N = 3;

   logic                        clock = 1'b0;
   logic                        reset;
   rob_entry_t [N-1:0]          headEntries;
   logic [N-1:0]                headValids;
   logic [N-1:0][ROB_IDX_W-1:0] headIdxs;
   logic [N-1:0]                headIsStore;
   logic [N-1:0]                headIsHalt;
   logic                        sqCommitReady;
   logic [1:0]                  robRetireCount;
   logic                        robMispredict;
   logic [ROB_IDX_W-1:0]        robMispredIdx;
   logic [0:0]                  sqCommitCount;
   logic                        bpRecoverEn;
   logic [63:0]                 freeMask;
   logic [N-1:0]                archWriteEnables;
   logic [N-1:0][REG_IDX_W-1:0] archWriteAddrs;
   logic [N-1:0][PRW-1:0]       archWritePhysRegs;
   logic                        halted;
   logic [63:0]                 instRetiredCnt;
   logic [63:0]                 mispredCnt;

   retire_ctrl #(.N(N), .PHYS_REGS(64), .STORE_PORTS(1), .RECOVER_CYCLES(2), .CNT_W(64)) dut (
      .clock(clock), .reset(reset), .headEntries(headEntries), .headValids(headValids),
      .headIdxs(headIdxs), .headIsStore(headIsStore), .headIsHalt(headIsHalt),
      .sqCommitReady(sqCommitReady), .robRetireCount(robRetireCount),
      .robMispredict(robMispredict), .robMispredIdx(robMispredIdx),
      .sqCommitCount(sqCommitCount), .bpRecoverEn(bpRecoverEn), .freeMask(freeMask),
      .archWriteEnables(archWriteEnables), .archWriteAddrs(archWriteAddrs),
      .archWritePhysRegs(archWritePhysRegs), .halted(halted),
      .instRetiredCnt(instRetiredCnt), .mispredCnt(mispredCnt));

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]       v, c, st, ht;
      logic [2:0][4:0]  rd;
      logic [2:0][5:0]  pv;
      logic             sqr;
      int               ecnt, esq;
      logic [2:0]       ewe;
      logic [63:0]      efree;
   } vec_t;

   typedef struct {
      logic [2:0]      we;
      logic [2:0][4:0] addr;
      logic [2:0][5:0] phys;
      logic [63:0]     free;
      logic            bp;
      longint          inst;
   } sb_t;

   sb_t    sbq[$];
   vec_t   tbl[8];
   int     checks = 0;
   int     failures = 0;
   longint cum = 0;

   localparam logic [2:0][4:0] RD_A  = {5'd5, 5'd6, 5'd0};
   localparam logic [2:0][5:0] PV_A  = {6'd40, 6'd41, 6'd0};
   localparam logic [2:0][4:0] RD_P  = {5'd5, 5'd6, 5'd7};
   localparam logic [2:0][5:0] PV_P  = {6'd40, 6'd41, 6'd42};
   localparam logic [63:0]     F40   = 64'd1 << 40;
   localparam logic [63:0]     F4041 = (64'd1 << 40) | (64'd1 << 41);
   localparam logic [63:0]     F_P   = (64'd1 << 40) | (64'd1 << 41) | (64'd1 << 42);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic set_lanes(input logic [2:0] v, c, st, ht, input logic [2:0][4:0] rd,
                            input logic [2:0][5:0] pv, input logic sqr);
      for (int w = 0; w < N; w++) begin
         headEntries[w]              = '0;
         headEntries[w].complete     = c[w];
         headEntries[w].arch_rd      = rd[w];
         headEntries[w].phys_rd      = 6'(12 - w);
         headEntries[w].prev_phys_rd = pv[w];
         headIdxs[w]                 = 5'(22 - w);
      end
      headValids    = v;
      headIsStore   = st;
      headIsHalt    = ht;
      sqCommitReady = sqr;
   endtask

   task automatic set_plain();
      set_lanes(3'b111, 3'b111, 3'b000, 3'b000, RD_P, PV_P, 1'b1);
   endtask

   // Expected arch map write data is taken from the lanes the bench drove.
   task automatic push_exp(input logic [2:0] we, input logic [63:0] fr, input logic bp);
      sb_t e;
      e.we = we; e.free = fr; e.bp = bp; e.inst = cum;
      for (int w = 0; w < N; w++) begin
         e.addr[w] = we[w] ? headEntries[w].arch_rd : 5'd0;
         e.phys[w] = we[w] ? 6'(12 - w) : 6'd0;
      end
      sbq.push_back(e);
   endtask

   task automatic pop_chk(input string nm);
      sb_t e;
      if (sbq.size() == 0) begin
         chk({nm, "_sb_empty"}, 64'd1, 64'd0);
         return;
      end
      e = sbq.pop_front();
      chk({nm, "_we"},   64'(archWriteEnables),  64'(e.we));
      chk({nm, "_addr"}, 64'(archWriteAddrs),    64'(e.addr));
      chk({nm, "_phys"}, 64'(archWritePhysRegs), 64'(e.phys));
      chk({nm, "_free"}, freeMask,               e.free);
      chk({nm, "_bp"},   64'(bpRecoverEn),       64'(e.bp));
      chk({nm, "_inst"}, instRetiredCnt,         64'(e.inst));
   endtask

   // One RUN-state step: drive at negedge, check comb, latch, check registered.
   task automatic comb_step(input string nm, input int ecnt, input logic [2:0] we,
                            input logic [63:0] fr, input logic bp);
      #1;
      chk({nm, "_cnt"}, 64'(robRetireCount), 64'(ecnt));
      cum += ecnt;
      push_exp(we, fr, bp);
      @(posedge clock); #1;
      pop_chk(nm);
   endtask

   function automatic vec_t mkv(input logic [2:0] v, c, st, input logic [2:0][4:0] rd,
                                input logic [2:0][5:0] pv, input logic sqr, input int ecnt,
                                input int esq, input logic [2:0] ewe, input logic [63:0] efree);
      vec_t t;
      t.v = v; t.c = c; t.st = st; t.ht = 3'b000; t.rd = rd; t.pv = pv; t.sqr = sqr;
      t.ecnt = ecnt; t.esq = esq; t.ewe = ewe; t.efree = efree;
      return t;
   endfunction

   initial begin
      tbl[0] = mkv(3'b111, 3'b111, 3'b000, RD_A, PV_A, 1'b1, 3, 0, 3'b110, F4041);
      tbl[1] = mkv(3'b111, 3'b101, 3'b000, RD_A, PV_A, 1'b1, 1, 0, 3'b100, F40);
      tbl[2] = mkv(3'b111, 3'b111, 3'b110, RD_A, PV_A, 1'b1, 1, 1, 3'b100, F40);
      tbl[3] = mkv(3'b111, 3'b111, 3'b100, RD_A, PV_A, 1'b0, 0, 0, 3'b000, 64'd0);
      tbl[4] = mkv(3'b011, 3'b111, 3'b000, RD_A, PV_A, 1'b1, 0, 0, 3'b000, 64'd0);
      tbl[5] = mkv(3'b110, 3'b111, 3'b000, {5'd7, 5'd0, 5'd3}, {6'd20, 6'd33, 6'd9},
                   1'b1, 2, 0, 3'b100, 64'd1 << 20);
      tbl[6] = mkv(3'b111, 3'b111, 3'b000, {5'd3, 5'd4, 5'd5}, {6'd0, 6'd9, 6'd0},
                   1'b1, 3, 0, 3'b111, 64'd1 << 9);
      tbl[7] = mkv(3'b111, 3'b111, 3'b001, RD_A, PV_A, 1'b0, 2, 0, 3'b110, F4041);

      // Reset state
      reset = 1'b0;
      set_plain();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_we", 64'(archWriteEnables), 64'd0);
      chk("rst_free", freeMask, 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_bp", 64'(bpRecoverEn), 64'd0);
      chk("rst_inst", instRetiredCnt, 64'd0);
      chk("rst_misp", mispredCnt, 64'd0);
      reset = 1'b1;

      // Table-driven RUN-state vectors
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         set_lanes(tbl[i].v, tbl[i].c, tbl[i].st, tbl[i].ht, tbl[i].rd, tbl[i].pv, tbl[i].sqr);
         #1;
         chk($sformatf("vec%0d_sq", i), 64'(sqCommitCount), 64'(tbl[i].esq));
         chk($sformatf("vec%0d_misp", i), 64'(robMispredict), 64'd0);
         comb_step($sformatf("vec%0d", i), tbl[i].ecnt, tbl[i].ewe, tbl[i].efree, 1'b0);
      end

      // Mispredict on lane 1 (direction), then two blocked recovery cycles
      @(negedge clock);
      set_lanes(3'b111, 3'b111, 3'b000, 3'b000, RD_A, PV_A, 1'b1);
      headEntries[1].branch       = 1'b1;
      headEntries[1].branch_taken = 1'b1;
      #1;
      chk("misp_flag", 64'(robMispredict), 64'd1);
      chk("misp_idx", 64'(robMispredIdx), 64'd21);
      comb_step("misp", 2, 3'b110, F4041, 1'b1);
      chk("misp_cnt", mispredCnt, 64'd1);
      @(negedge clock); set_plain();
      comb_step("rec1", 0, 3'b000, 64'd0, 1'b0);
      @(negedge clock); set_plain();
      comb_step("rec2", 0, 3'b000, 64'd0, 1'b0);
      @(negedge clock); set_plain();
      comb_step("resume", 3, 3'b111, F_P, 1'b0);

      // Halt on lane 1: lane 0 must not retire, halted sticks until reset
      @(negedge clock);
      set_lanes(3'b111, 3'b111, 3'b000, 3'b010, RD_P, PV_P, 1'b1);
      comb_step("halt", 2, 3'b110, F4041, 1'b0);
      chk("halt_set", 64'(halted), 64'd1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clock); set_plain();
         comb_step($sformatf("halted%0d", k), 0, 3'b000, 64'd0, 1'b0);
         chk($sformatf("halted%0d_flag", k), 64'(halted), 64'd1);
      end
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      chk("hrst_halted", 64'(halted), 64'd0);
      chk("hrst_inst", instRetiredCnt, 64'd0);
      chk("hrst_misp", mispredCnt, 64'd0);
      cum = 0;
      @(negedge clock); reset = 1'b1;
      comb_step("hrst_resume", 3, 3'b111, F_P, 1'b0);

      // Halt + target mispredict on lane 2: mispredict wins; reset in RECOVER
      @(negedge clock);
      set_lanes(3'b111, 3'b111, 3'b000, 3'b100, RD_P, PV_P, 1'b1);
      headEntries[2].branch        = 1'b1;
      headEntries[2].pred_taken    = 1'b1;
      headEntries[2].branch_taken  = 1'b1;
      headEntries[2].pred_target   = 32'h100;
      headEntries[2].branch_target = 32'h200;
      #1;
      chk("hm_misp", 64'(robMispredict), 64'd1);
      chk("hm_idx", 64'(robMispredIdx), 64'd20);
      comb_step("hm", 1, 3'b100, F40, 1'b1);
      chk("hm_halted", 64'(halted), 64'd0);
      chk("hm_mcnt", mispredCnt, 64'd1);
      @(negedge clock); set_plain(); reset = 1'b0;
      #1;
      chk("rrec_cnt", 64'(robRetireCount), 64'd0);
      @(posedge clock); #1;
      chk("rrec_bp", 64'(bpRecoverEn), 64'd0);
      chk("rrec_inst", instRetiredCnt, 64'd0);
      cum = 0;
      @(negedge clock); reset = 1'b1;
      comb_step("rrec_resume", 3, 3'b111, F_P, 1'b0);

      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
